// File: rtl/conv1d_psum_drain.sv
// Psum chain drain: accumulates bias plus a group of psums into one output point,
// then requantizes (round, shift, optional ReLU, saturate) onto a 1-deep valid/ready output.
module conv1d_psum_drain #(
  parameter int WIDTH_DATA = 8,
  parameter int ACC_W      = 32,
  parameter int SHIFT_W    = 5,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [2*WIDTH_DATA-1:0]   psum_data,
  input  logic                      psum_last,
  input  logic [ACC_W-1:0]          cfg_bias,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      cfg_relu,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_DATA-1:0]     out_data,
  output logic [CNT_W-1:0]          sat_cnt
);

  localparam int PSUM_W = 2 * WIDTH_DATA;
  localparam int MAX_I  = (2 ** (WIDTH_DATA - 1)) - 1;
  localparam int MIN_I  = -(2 ** (WIDTH_DATA - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(MAX_I);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(MIN_I);
  localparam logic signed [ACC_W:0] RND_ONE = (ACC_W + 1)'(1);

  // state    | meaning
  // ST_IDLE  | no group open; next beat seeds the accumulator from cfg_bias
  // ST_ACCUM | group open; r_acc holds bias plus psums accepted so far
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACC_W-1:0]      r_acc;
  logic                  r_out_valid;
  logic [WIDTH_DATA-1:0] r_out_data;
  logic [CNT_W-1:0]      r_sat_cnt;

  logic                  w_beat;
  logic                  w_acc_step;
  logic                  w_emit;
  logic [ACC_W-1:0]      w_psum_ext;
  logic [ACC_W-1:0]      w_base;
  logic [ACC_W-1:0]      w_sum;
  logic signed [ACC_W:0] w_sum_x;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_rounded;
  logic signed [ACC_W:0] w_shifted;
  logic signed [ACC_W:0] w_relu;
  logic                  w_sat_hi;
  logic                  w_sat_lo;
  logic                  w_sat;
  logic [WIDTH_DATA-1:0] w_q;

  // Ready depends only on the output register and out_ready, never on psum_valid.
  assign psum_ready = ~r_out_valid | out_ready;
  assign w_beat     = psum_valid & psum_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_step  = 1'b0;
    w_emit      = 1'b0;
    if (w_beat) begin
      if (psum_last) begin
        w_emit      = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_acc_step  = 1'b1;
        w_state_nxt = ST_ACCUM;
      end
    end
  end

  assign w_psum_ext = {{(ACC_W - PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
  assign w_base     = (r_state == ST_ACCUM) ? r_acc : cfg_bias;
  assign w_sum      = w_base + w_psum_ext;

  // One guard bit keeps the rounding add from wrapping near the accumulator limits.
  assign w_sum_x   = $signed({w_sum[ACC_W-1], w_sum});
  assign w_rnd     = (cfg_shift == '0) ? '0 : (RND_ONE << (cfg_shift - SHIFT_W'(1)));
  assign w_rounded = w_sum_x + w_rnd;
  assign w_shifted = w_rounded >>> cfg_shift;
  assign w_relu    = (cfg_relu && w_shifted[ACC_W]) ? '0 : w_shifted;

  assign w_sat_hi = (w_relu > SAT_MAX);
  assign w_sat_lo = (w_relu < SAT_MIN);
  assign w_sat    = w_sat_hi | w_sat_lo;
  assign w_q      = w_sat_hi ? SAT_MAX[WIDTH_DATA-1:0] :
                    w_sat_lo ? SAT_MIN[WIDTH_DATA-1:0] :
                               w_relu[WIDTH_DATA-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_acc_step) r_acc <= w_sum;
      if (w_emit) begin
        r_out_data  <= w_q;
        r_out_valid <= 1'b1;
        if (w_sat && (r_sat_cnt != '1)) r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_cnt   = r_sat_cnt;

endmodule
